// File: rtl/seq_divider_16by8.sv
// seq_divider_16by8: multi-cycle restoring unsigned divider, one quotient bit per clock.
// Handshake: start (sampled in IDLE) -> busy -> one-cycle done with registered results.
// A zero divisor finishes in one cycle with quotient all ones and div_by_zero set.
// Optional macro DIV_EARLY_EXIT_EN: dividend < divisor finishes in one cycle through FAST.
module seq_divider_16by8 #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CNT_W = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ZERO,
        ST_FAST
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    q_q, q_d;
    logic [VW:0]      p_q, p_d;
    logic [VW-1:0]    div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DW-1:0]    quotient_q, quotient_d;
    logic [VW-1:0]    remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [VW:0]      p_shift;
    logic [VW:0]      p_next;
    logic [DW-1:0]    q_next;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        p_shift = {p_q[VW-1:0], q_q[DW-1]};
        q_next  = {q_q[DW-2:0], 1'b0};
        p_next  = p_shift;
        if (p_shift >= {1'b0, div_q}) begin
            p_next    = p_shift - {1'b0, div_q};
            q_next[0] = 1'b1;
        end
    end

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        p_d         = p_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d    = dividend;
                    div_d  = divisor;
                    p_d    = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (divisor == '0) begin
                        state_d = ST_ZERO;
`ifdef DIV_EARLY_EXIT_EN
                    end else if (dividend < DW'(divisor)) begin
                        state_d = ST_FAST;
`endif
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                p_d   = p_next;
                q_d   = q_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    quotient_d  = q_next;
                    remainder_d = p_next[VW-1:0];
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_ZERO: begin
                quotient_d  = '1;
                remainder_d = q_q[VW-1:0];
                dbz_d       = 1'b1;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_FAST: begin
                // Dividend already smaller than divisor: it is the remainder.
                quotient_d  = '0;
                remainder_d = q_q[VW-1:0];
                dbz_d       = 1'b0;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            p_q         <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            p_q         <= p_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Testbench for seq_divider_16by8: vector table, hand-written handshake sequences,
// and randomized operands checked against plain arithmetic.
module tb_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_tot = 0;
    int n_bad = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    seq_divider_16by8 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] exp_q;
        logic [7:0]  exp_r;
        logic        exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic bad_event(input string name);
        n_tot++;
        n_bad++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    // Issue one start at the next edge (E0); returns #1 after E0.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Count cycles until done; busy must be high before it and low with it.
    task automatic wait_done(input string name, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            check({name, "_busy"}, 32'(busy), 32'd1);
        end
        if (lat < 0) bad_event({name, "_done_timeout"});
        else check({name, "_busy_with_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_results(input string name, input logic [15:0] eq, input logic [7:0] er,
                                 input logic ez);
        check({name, "_quotient"}, 32'(quotient), 32'(eq));
        check({name, "_remainder"}, 32'(remainder), 32'(er));
        check({name, "_dbz"}, 32'(div_by_zero), 32'(ez));
    endtask

    // Full operation: start, latency, results, then one idle cycle to see done drop and results hold.
    task automatic run_check(input string name, input logic [15:0] a, input logic [7:0] b,
                             input logic [15:0] eq, input logic [7:0] er, input logic ez,
                             input int elat);
        int lat;
        start_op(a, b);
        check({name, "_busy_start"}, 32'(busy), 32'd1);
        wait_done(name, lat);
        check({name, "_latency"}, 32'(lat), 32'(elat));
        check_results(name, eq, er, ez);
        @(posedge clk);
        #1;
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_held_quotient"}, 32'(quotient), 32'(eq));
    endtask

    // Reference model from the arithmetic definition.
    task automatic model(input logic [15:0] a, input logic [7:0] b, output logic [15:0] eq,
                         output logic [7:0] er, output logic ez, output int elat);
        if (b == 0) begin
            eq = 16'hFFFF; er = a[7:0]; ez = 1'b1; elat = 1;
        end else begin
            eq = a / {8'd0, b};
            er = 8'(a % {8'd0, b});
            ez = 1'b0;
            elat = (EARLY && (a < {8'd0, b})) ? 1 : 16;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int fast = EARLY ? 1 : 16;

        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16};
        vecs[1] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,   1'b0, 16};
        vecs[2] = '{16'd200,   8'd0,   16'hFFFF,  8'hC8,  1'b1, 1};
        vecs[3] = '{16'd10,    8'd3,   16'd3,     8'd1,   1'b0, 16};
        vecs[4] = '{16'd5,     8'd9,   16'd0,     8'd5,   1'b0, fast};
        vecs[5] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b0, 16};
        vecs[6] = '{16'd300,   8'd16,  16'd18,    8'd12,  1'b0, 16};
        vecs[7] = '{16'd0,     8'd0,   16'hFFFF,  8'd0,   1'b1, 1};
        vecs[8] = '{16'd254,   8'd255, 16'd0,     8'd254, 1'b0, fast};
        vecs[9] = '{16'd255,   8'd255, 16'd1,     8'd0,   1'b0, 16};

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].exp_q,
                      vecs[i].exp_r, vecs[i].exp_z, vecs[i].exp_lat);

        // Back-to-back: second start issued in the done cycle.
        start_op(16'hFFFF, 8'hFF);
        wait_done("b2b_first", lat);
        check("b2b_first_latency", 32'(lat), 32'd16);
        check_results("b2b_first", 16'd257, 8'd0, 1'b0);
        start_op(16'h0100, 8'h01);
        check("b2b_second_busy", 32'(busy), 32'd1);
        wait_done("b2b_second", lat);
        check("b2b_second_latency", 32'(lat), 32'd16);
        check_results("b2b_second", 16'd256, 8'd0, 1'b0);

        // Zero divisor followed directly by a normal division.
        run_check("zero_then", 16'd200, 8'd0, 16'hFFFF, 8'hC8, 1'b1, 1);
        run_check("then_normal", 16'd10, 8'd3, 16'd3, 8'd1, 1'b0, 16);

        // Start while busy is ignored.
        start_op(16'd1000, 8'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        dividend = 16'd50;
        divisor = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", lat);
        check("ignore_latency", 32'(lat + 4), 32'd16);
        check_results("ignore", 16'd142, 8'd6, 1'b0);
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("ignore_no_second_done", 32'(ndone), 32'd0);
        check("ignore_held_quotient", 32'(quotient), 32'd142);

        // Asynchronous reset mid-operation.
        start_op(16'd1000, 8'd7);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_quotient", 32'(quotient), 32'd0);
        check("arst_remainder", 32'(remainder), 32'd0);
        check("arst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        run_check("after_rst", 16'd81, 8'd9, 16'd9, 8'd0, 1'b0, 16);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 120; i++) begin
            logic [15:0] a, eq;
            logic [7:0]  b, er;
            logic        ez;
            int          elat;
            int          sel = int'($urandom_range(0, 9));
            b = 8'($urandom);
            a = 16'($urandom);
            if (sel == 0) b = 8'd0;
            else if (sel < 3) begin
                b = 8'($urandom_range(1, 255));
                a = 16'($urandom_range(0, int'(b) - 1));
            end else if (sel == 3) b = 8'd1;
            model(a, b, eq, er, ez, elat);
            run_check($sformatf("rnd%0d", i), a, b, eq, er, ez, elat);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider_16by8.md
Name: seq_divider_16by8

Overview:
- Multi-cycle restoring unsigned divider: quotient = dividend / divisor, remainder = dividend % divisor.
- Inverse companion to the team's 8x8 Dadda multiplier datapath; used to check multiplier products and to normalise them.
- Produces one quotient bit per clock behind a start/busy/done handshake.
- Results are exact; this block uses no approximate compressors.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width; must satisfy VW <= DW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DW  numerator; captured on the accepted start edge.
- divisor  input  VW  denominator; captured on the accepted start edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  DW  registered result; held until the next done.
- remainder  output  VW  registered result; held until the next done.
- div_by_zero  output  1  flag for the last completed operation; updated with done.

Behaviour:
- Reset, asynchronous, any state: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared. An operation in flight is abandoned with no done.
- States:
  - IDLE: start=1 at edge E0 → capture operands, busy=1.
  - If divisor==0 → ZERO; else → CALC, iteration count=0.
  - CALC: each edge performs one restoring step.
    - Partial remainder P (VW+1 bits) = {P[VW-1:0], Q[DW-1]}.
    - Shift Q left.
    - If P >= divisor: P = P - divisor and Q[0] = 1.
    - Iteration count increments.
  - Edge of iteration DW (edge E0+DW): quotient<=Q, remainder<=P[VW-1:0], div_by_zero<=0, done=1, busy=0, state → IDLE.
  - ZERO: next edge (E0+1): quotient<=all ones, remainder<=dividend[VW-1:0], div_by_zero<=1, done=1, busy=0 → IDLE.
- Latency, start edge to done-high cycle:
  - DW cycles (16) for a nonzero divisor.
  - 1 cycle for a zero divisor.
- Timing:
  - done stays high for exactly one cycle.
  - busy and done are never high together.
  - start may be high in the done cycle; it is accepted, so back-to-back operations have no idle cycle.
- start while busy=1 is ignored. It is not queued and operands are not re-captured.
- Operand inputs are don't-care except on the accepted start edge.
- quotient, remainder and div_by_zero change only on a done edge or on reset.
- Arithmetic:
  - Unsigned.
  - The comparison and subtraction use the VW+1-bit P, so no overflow is possible.
  - The result always satisfies quotient*divisor + remainder == dividend when divisor != 0.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE, an accepted start with divisor != 0 and dividend < divisor (zero-extended compare) goes to a FAST state.
  - FAST: next edge sets quotient<=0, remainder<=dividend[VW-1:0], div_by_zero<=0, done=1. Latency is 1 cycle.
  - All other cases are unchanged.
- Undefined: such operands take the full DW-cycle CALC path and give identical results.

Test Plan:
- start with dividend=1000, divisor=7 → done exactly 16 cycles after the start edge; quotient=142, remainder=6, div_by_zero=0; busy high for those 16 cycles.
- dividend=16'hFFFF, divisor=8'hFF → quotient=257, remainder=0. Then, in the done cycle, start with dividend=16'h0100, divisor=8'h01 → second done 16 cycles later with quotient=256, remainder=0.
- dividend=200, divisor=0 → done 1 cycle after start; quotient=16'hFFFF, remainder=8'hC8, div_by_zero=1. A following 10/3 → quotient=3, remainder=1, div_by_zero=0.
- dividend=5, divisor=9 → quotient=0, remainder=5. Done after 1 cycle with DIV_EARLY_EXIT_EN, after 16 cycles without it.
- Start 1000/7, pulse start again with 50/5 at cycle 4 → only one done; quotient=142, remainder=6. The second request is dropped.
- Start 1000/7, assert rst asynchronously at cycle 8 mid-clock → outputs go to 0 immediately and no done appears. After release, 81/9 → quotient=9, remainder=0 in 16 cycles.
